// File: rtl/zap_wb_arb_pkg.sv
// zap_wb_arb_pkg -- shared definitions for the two-master Wishbone arbiter.
// Contents: arbiter state encoding, one-hot grant constants and a helper
// that turns a state into its grant vector.
package zap_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // One-hot owner for a given arbiter state; unused encodings own nothing.
  function automatic logic [1:0] grant_of(input arb_state_t st);
    logic [1:0] g;
    case (st)
      GNT_M0:  g = GRANT_M0;
      GNT_M1:  g = GRANT_M1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/zap_wb_arb_mux.sv
// zap_wb_arb_mux -- combinational bus steering for zap_wb_arbiter.
// Ports:
//   grant_s        one-hot owner (01=m0, 10=m1, 00=none)
//   tmo_hit_s      watchdog expiry: kills stb and raises err to the owner
//   i_m0_* / i_m1_* master request buses
//   i_s_ack/i_s_err slave response
//   o_s_*          slave request bus (all zero when nobody owns the bus)
//   o_m0_ack/err, o_m1_ack/err  responses; only the owner ever sees one
module zap_wb_arb_mux
  import zap_wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]              grant_s,
  input  logic                    tmo_hit_s,
  input  logic                    i_m0_cyc,
  input  logic                    i_m0_stb,
  input  logic                    i_m0_we,
  input  logic [ADDR_WIDTH-1:0]   i_m0_adr,
  input  logic [DATA_WIDTH-1:0]   i_m0_dat,
  input  logic [DATA_WIDTH/8-1:0] i_m0_sel,
  input  logic                    i_m1_cyc,
  input  logic                    i_m1_stb,
  input  logic                    i_m1_we,
  input  logic [ADDR_WIDTH-1:0]   i_m1_adr,
  input  logic [DATA_WIDTH-1:0]   i_m1_dat,
  input  logic [DATA_WIDTH/8-1:0] i_m1_sel,
  input  logic                    i_s_ack,
  input  logic                    i_s_err,
  output logic                    o_s_cyc,
  output logic                    o_s_stb,
  output logic                    o_s_we,
  output logic [ADDR_WIDTH-1:0]   o_s_adr,
  output logic [DATA_WIDTH-1:0]   o_s_dat,
  output logic [DATA_WIDTH/8-1:0] o_s_sel,
  output logic                    o_m0_ack,
  output logic                    o_m0_err,
  output logic                    o_m1_ack,
  output logic                    o_m1_err
);

  // Steer the owner's request to the slave and the slave's response back.
  // Responses are qualified by the owner's cyc so a reply that lands as the
  // owner lets go is dropped rather than delivered to a master not listening.
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_adr  = {ADDR_WIDTH{1'b0}};
    o_s_dat  = {DATA_WIDTH{1'b0}};
    o_s_sel  = {(DATA_WIDTH/8){1'b0}};
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    case (grant_s)
      GRANT_M0: begin
        o_s_cyc  = i_m0_cyc;
        o_s_stb  = i_m0_stb & ~tmo_hit_s;
        o_s_we   = i_m0_we;
        o_s_adr  = i_m0_adr;
        o_s_dat  = i_m0_dat;
        o_s_sel  = i_m0_sel;
        o_m0_ack = i_m0_cyc & i_s_ack;
        o_m0_err = i_m0_cyc & (i_s_err | tmo_hit_s);
      end
      GRANT_M1: begin
        o_s_cyc  = i_m1_cyc;
        o_s_stb  = i_m1_stb & ~tmo_hit_s;
        o_s_we   = i_m1_we;
        o_s_adr  = i_m1_adr;
        o_s_dat  = i_m1_dat;
        o_s_sel  = i_m1_sel;
        o_m1_ack = i_m1_cyc & i_s_ack;
        o_m1_err = i_m1_cyc & (i_s_err | tmo_hit_s);
      end
      default: begin
        o_s_cyc = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/zap_wb_arbiter.sv
// zap_wb_arbiter -- two-master / one-slave Wishbone B3 classic arbiter.
// Master 0 is the ZAP data port, master 1 the code port. Round-robin with a
// registered grant that is held for the owner's whole cyc (no preemption),
// and direct handoff to a waiting master without an idle cycle.
// Ports:
//   i_clk, i_reset_n         clock, synchronous active-low reset
//   i_m0_* / o_m0_*          data master bus
//   i_m1_* / o_m1_*          code master bus
//   o_s_* / i_s_*            slave bus
//   o_grant                  one-hot owner (debug): 01=m0, 10=m1, 00=none
// Build option: define ZAP_WB_ARB_TIMEOUT_EN to add a no-ack watchdog that
// returns err to the owner after TIMEOUT_CYCLES strobed cycles.
module zap_wb_arbiter
  import zap_wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_m0_cyc,
  input  logic                    i_m0_stb,
  input  logic                    i_m0_we,
  input  logic [ADDR_WIDTH-1:0]   i_m0_adr,
  input  logic [DATA_WIDTH-1:0]   i_m0_dat,
  input  logic [DATA_WIDTH/8-1:0] i_m0_sel,
  output logic [DATA_WIDTH-1:0]   o_m0_dat,
  output logic                    o_m0_ack,
  output logic                    o_m0_err,
  input  logic                    i_m1_cyc,
  input  logic                    i_m1_stb,
  input  logic                    i_m1_we,
  input  logic [ADDR_WIDTH-1:0]   i_m1_adr,
  input  logic [DATA_WIDTH-1:0]   i_m1_dat,
  input  logic [DATA_WIDTH/8-1:0] i_m1_sel,
  output logic [DATA_WIDTH-1:0]   o_m1_dat,
  output logic                    o_m1_ack,
  output logic                    o_m1_err,
  output logic                    o_s_cyc,
  output logic                    o_s_stb,
  output logic                    o_s_we,
  output logic [ADDR_WIDTH-1:0]   o_s_adr,
  output logic [DATA_WIDTH-1:0]   o_s_dat,
  output logic [DATA_WIDTH/8-1:0] o_s_sel,
  input  logic [DATA_WIDTH-1:0]   i_s_dat,
  input  logic                    i_s_ack,
  input  logic                    i_s_err,
  output logic [1:0]              o_grant
);

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  logic       last_r;       // 1 when m1 was the most recent owner
  logic [1:0] grant_s;
  logic       owner_stb_s;
  logic       tmo_hit_s;

  // Next owner: pick in IDLE, otherwise hold until the owner drops cyc.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          state_nxt_s = last_r ? GNT_M0 : GNT_M1;
        end else if (i_m0_cyc) begin
          state_nxt_s = GNT_M0;
        end else if (i_m1_cyc) begin
          state_nxt_s = GNT_M1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_M0: begin
        if (!i_m0_cyc) begin
          state_nxt_s = i_m1_cyc ? GNT_M1 : IDLE;
        end else begin
          state_nxt_s = GNT_M0;
        end
      end
      GNT_M1: begin
        if (!i_m1_cyc) begin
          state_nxt_s = i_m0_cyc ? GNT_M0 : IDLE;
        end else begin
          state_nxt_s = GNT_M1;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant state and round-robin pointer; last starts at m1 so m0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      case (state_nxt_s)
        GNT_M0:  last_r <= 1'b0;
        GNT_M1:  last_r <= 1'b1;
        default: last_r <= last_r;
      endcase
    end
  end

  assign grant_s = grant_of(state_r);
  assign o_grant = grant_s;

  // Strobe of whichever master currently owns the bus.
  always_comb begin
    owner_stb_s = 1'b0;
    case (state_r)
      GNT_M0:  owner_stb_s = i_m0_stb;
      GNT_M1:  owner_stb_s = i_m1_stb;
      default: owner_stb_s = 1'b0;
    endcase
  end

`ifdef ZAP_WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt_r;

  assign tmo_hit_s = owner_stb_s && (tmo_cnt_r == TMO_LIMIT);

  // Watchdog: counts strobed cycles with no reply; restarts on any reply,
  // owner change, idle strobe or its own expiry.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else if ((state_nxt_s != state_r) || !owner_stb_s || i_s_ack || i_s_err || tmo_hit_s) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end
`else
  // Without the watchdog the arbiter waits for the slave indefinitely.
  localparam int UNUSED_TMO_LIMIT = TIMEOUT_CYCLES;
  assign tmo_hit_s = 1'b0;
`endif

  // Read data goes to both masters; only the acked one will consume it.
  assign o_m0_dat = i_s_dat;
  assign o_m1_dat = i_s_dat;

  zap_wb_arb_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .grant_s  (grant_s),
    .tmo_hit_s(tmo_hit_s),
    .i_m0_cyc (i_m0_cyc),
    .i_m0_stb (i_m0_stb),
    .i_m0_we  (i_m0_we),
    .i_m0_adr (i_m0_adr),
    .i_m0_dat (i_m0_dat),
    .i_m0_sel (i_m0_sel),
    .i_m1_cyc (i_m1_cyc),
    .i_m1_stb (i_m1_stb),
    .i_m1_we  (i_m1_we),
    .i_m1_adr (i_m1_adr),
    .i_m1_dat (i_m1_dat),
    .i_m1_sel (i_m1_sel),
    .i_s_ack  (i_s_ack),
    .i_s_err  (i_s_err),
    .o_s_cyc  (o_s_cyc),
    .o_s_stb  (o_s_stb),
    .o_s_we   (o_s_we),
    .o_s_adr  (o_s_adr),
    .o_s_dat  (o_s_dat),
    .o_s_sel  (o_s_sel),
    .o_m0_ack (o_m0_ack),
    .o_m0_err (o_m0_err),
    .o_m1_ack (o_m1_ack),
    .o_m1_err (o_m1_err)
  );

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// tb_zap_wb_arbiter -- directed self-checking bench for zap_wb_arbiter.
// A behavioural owner/round-robin model is compared against every output on
// every falling edge; directed sequences add literal expectations.
module tb_zap_wb_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat, m1_dat;
  logic [SW-1:0] m0_sel, m1_sel;
  logic [DW-1:0] o_m0_dat, o_m1_dat;
  logic          o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [SW-1:0] s_sel;
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err;
  logic [1:0]    grant;

  zap_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_adr(m0_adr),
    .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack),
    .o_m0_err(o_m0_err),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_adr(m1_adr),
    .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
    .o_m1_err(o_m1_err),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr),
    .o_s_dat(s_wdat), .o_s_sel(s_sel), .i_s_dat(s_dat), .i_s_ack(s_ack),
    .i_s_err(s_err), .o_grant(grant)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int owner_m = 0;  // 0 = nobody, 1 = m0, 2 = m1
  int last_m  = 2;  // most recent owner
  int tcnt_m  = 0;  // strobed cycles without a reply

  function automatic logic own_stb();
    return (owner_m == 1) ? m0_stb : (owner_m == 2) ? m1_stb : 1'b0;
  endfunction

  function automatic logic tmo_now();
`ifdef ZAP_WB_ARB_TIMEOUT_EN
    return (owner_m != 0) && own_stb() && (tcnt_m == TMO);
`else
    return 1'b0;
`endif
  endfunction

  int nxt_m;
  always @(posedge clk) begin
    if (!rst_n) begin
      owner_m <= 0;
      last_m  <= 2;
      tcnt_m  <= 0;
    end else begin
      nxt_m = owner_m;
      if (owner_m == 0) begin
        if (m0_cyc && m1_cyc) nxt_m = (last_m == 1) ? 2 : 1;
        else if (m0_cyc)      nxt_m = 1;
        else if (m1_cyc)      nxt_m = 2;
      end else if (owner_m == 1 && !m0_cyc) begin
        nxt_m = m1_cyc ? 2 : 0;
      end else if (owner_m == 2 && !m1_cyc) begin
        nxt_m = m0_cyc ? 1 : 0;
      end
      owner_m <= nxt_m;
      if (nxt_m != 0) last_m <= nxt_m;
      if (nxt_m != owner_m || !own_stb() || s_ack || s_err || tmo_now()) tcnt_m <= 0;
      else tcnt_m <= tcnt_m + 1;
    end
  end

  // Compare every output against the model each cycle.
  logic          e_cyc, e_stb, e_we, e_a0, e_e0, e_a1, e_e1, e_tmo;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat;
  logic [SW-1:0] e_sel;
  logic [1:0]    e_grant;
  always @(negedge clk) begin
    if (chk_en) begin
      e_tmo = tmo_now();
      {e_cyc, e_stb, e_we, e_a0, e_e0, e_a1, e_e1} = 7'b0;
      e_adr = '0; e_dat = '0; e_sel = '0; e_grant = 2'b00;
      if (owner_m == 1) begin
        e_cyc = m0_cyc; e_stb = m0_stb && !e_tmo; e_we = m0_we;
        e_adr = m0_adr; e_dat = m0_dat; e_sel = m0_sel;
        e_a0 = m0_cyc && s_ack; e_e0 = m0_cyc && (s_err || e_tmo);
        e_grant = 2'b01;
      end else if (owner_m == 2) begin
        e_cyc = m1_cyc; e_stb = m1_stb && !e_tmo; e_we = m1_we;
        e_adr = m1_adr; e_dat = m1_dat; e_sel = m1_sel;
        e_a1 = m1_cyc && s_ack; e_e1 = m1_cyc && (s_err || e_tmo);
        e_grant = 2'b10;
      end
      chk("m_s_ctl", {s_cyc, s_stb, s_we, s_sel}, {e_cyc, e_stb, e_we, e_sel});
      chk("m_s_adr", s_adr, e_adr);
      chk("m_s_dat", s_wdat, e_dat);
      chk("m_resp", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}, {e_a0, e_e0, e_a1, e_e1});
      chk("m_grant", grant, e_grant);
      chk("m_rdat", {o_m0_dat, o_m1_dat}, {s_dat, s_dat});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acks;
  int errs;
  int err_idx;

  initial begin
    rst_n = 1'b0;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = 6'b0;
    m0_adr = '0; m1_adr = '0; m0_dat = '0; m1_dat = '0; m0_sel = '0; m1_sel = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_cyc", s_cyc, 1'b0);
    chk("rst_grant", grant, 2'b00);
    tick();
    rst_n = 1'b1;

    // Single m0 read
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h0000_0100; m0_sel = 4'hF;
    @(negedge clk); chk("t1_no_comb_cyc", s_cyc, 1'b0);
    tick();
    @(negedge clk); chk("t1_cyc", s_cyc, 1'b1); chk("t1_grant", grant, 2'b01);
    tick();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_ack", o_m0_ack, 1'b1); chk("t1_dat", o_m0_dat, 32'hDEAD_BEEF);
    chk("t1_m1_ack", o_m1_ack, 1'b0);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk); chk("t1_ack_once", o_m0_ack, 1'b0);
    tick();
    @(negedge clk); chk("t1_idle", grant, 2'b00);

    // Simultaneous requests straight out of reset
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h0000_0200;
    m0_dat = 32'hCAFE_0001; m0_sel = 4'hF;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h0; m1_sel = 4'hF;
    @(negedge clk); chk("t2_wait", grant, 2'b00);
    tick();
    @(negedge clk);
    chk("t2_first", grant, 2'b01); chk("t2_adr", s_adr, 32'h0000_0200);
    chk("t2_we", s_we, 1'b1); chk("t2_model_owner", owner_m, 1);
    tick(); s_ack = 1'b1;
    @(negedge clk); chk("t2_m0_ack", {o_m0_ack, o_m1_ack}, 2'b10);
    tick(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    tick();
    @(negedge clk);
    chk("t2_handoff", grant, 2'b10); chk("t2_m1_adr", s_adr, 32'h0);
    chk("t2_model_owner2", owner_m, 2);
    tick(); s_ack = 1'b1; s_dat = 32'h1234_5678;
    @(negedge clk); chk("t2_m1_ack", {o_m1_ack, o_m1_dat}, {1'b1, 32'h1234_5678});
    tick(); s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    @(negedge clk); chk("t2_idle", grant, 2'b00);
    tick(); m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    @(negedge clk); chk("t2_tie2_m0", grant, 2'b01);
    tick(); m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    @(negedge clk); chk("t2_tie2_m1", grant, 2'b10);
    tick(); m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();

    // Burst hold: m1 keeps the bus for four beats while m0 waits
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0040;
    tick();
    @(negedge clk); chk("t3_m1", grant, 2'b10);
    tick(); m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0300;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      m1_adr = 32'h0000_0040 + 32'(4 * i); s_ack = 1'b1; s_dat = 32'h0000_00A0 + 32'(i);
      @(negedge clk);
      if (o_m1_ack) acks++;
      chk("t3_hold", grant, 2'b10);
      chk("t3_m0_ack", o_m0_ack, 1'b0);
    end
    tick(); s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    @(negedge clk); chk("t3_still_m1", grant, 2'b10);
    tick();
    @(negedge clk); chk("t3_to_m0", grant, 2'b01); chk("t3_acks", acks, 4);
    tick(); m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();

    // Reset in the middle of an m0 write
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h0000_0500;
    m0_dat = 32'h0000_0055; m0_sel = 4'h3;
    tick();
    @(negedge clk); chk("t4_stb", {grant, s_stb}, 3'b011);
    tick(); rst_n = 1'b0;
    tick(); s_ack = 1'b1;
    @(negedge clk);
    chk("t4_cyc", s_cyc, 1'b0); chk("t4_grant", grant, 2'b00);
    chk("t4_late_ack", o_m0_ack, 1'b0);
    tick(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; rst_n = 1'b1;
    tick();

    // Error passthrough
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0600; m0_sel = 4'hF;
    tick();
    @(negedge clk); chk("t5_grant", grant, 2'b01);
    tick(); s_err = 1'b1;
    @(negedge clk); chk("t5_err", {o_m0_err, o_m1_err}, 2'b10);
    tick(); s_err = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk); chk("t5_err_once", o_m0_err, 1'b0);
    tick();

    // Unanswered m1 read
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0700;
    errs = 0; err_idx = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      if (o_m1_err) begin
        errs++;
        err_idx = i;
      end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
      if (i == TMO) chk("t6_err_stb", {o_m1_err, s_stb}, 2'b10);
`endif
    end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
    chk("t6_err_count", errs, 1);
    chk("t6_err_idx", err_idx, TMO);
`else
    chk("t6_no_err", errs, 0);
`endif
    tick(); m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
